// File: rtl/adc_pkg.sv
// adc_pkg: FSM state encoding, default parameters, timer width and round-robin channel pick
package adc_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CONVERT, HOLD} state_t;
  localparam int ADC_BITS_DEF = 10;
  localparam int SETTLE_DEF = 2;
  localparam int CONV_DEF = 12;
  localparam int CNT_W = 6;
  function automatic logic [2:0] next_chan(input logic [2:0] c, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] k;
    r = c;
    for (int i = 7; i >= 1; i--) begin
      k = c + i[2:0];
      if (m[k]) r = k;
    end
    return r;
  endfunction
endpackage

// File: rtl/adc_cycle_timer.sv
// adc_cycle_timer: loadable down-counter; ports clk/reset, load+load_val, count enable, cnt value, expire at zero
module adc_cycle_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         expire
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (count && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt = cnt_q;
  assign expire = cnt_q == '0;
endmodule

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: round-robin SAR scan; in enable/chan_mask/adc_eoc/adc_data/sample_ready/err_clr, out ADCctrl/start/sample_*/timeout_err
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int ADC_BITS = ADC_BITS_DEF,
  parameter int SETTLE_CYCLES = SETTLE_DEF,
  parameter int CONV_CYCLES = CONV_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [7:0]          chan_mask,
  input  logic                adc_eoc,
  input  logic [ADC_BITS-1:0] adc_data,
  input  logic                sample_ready,
  input  logic                err_clr,
  output logic [7:0]          ADCctrl,
  output logic                start,
  output logic                sample_valid,
  output logic [ADC_BITS-1:0] sample_data,
  output logic [2:0]          sample_chan,
  output logic                timeout_err
);
  state_t state_q, state_d;
  logic [2:0] chan_q, chan_d, schan_q, schan_d;
  logic [ADC_BITS-1:0] data_q, data_d;
  logic valid_q, valid_d, err_q, err_d;
  logic go, first, hit, tmo, adv, settle_done, load, count, expire;
  logic [CNT_W-1:0] load_val, tcnt;
  adc_cycle_timer #(.W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .count(count),
    .load_val(load_val), .cnt(tcnt), .expire(expire)
  );
  // The timer is loaded with CONV_CYCLES on entering CONVERT, so that value marks the start cycle
  // and zero marks the last cycle in which adc_eoc is still accepted.
  always_comb begin
    go = enable && |chan_mask;
    first = state_q == CONVERT && tcnt == CNT_W'(CONV_CYCLES);
    hit = state_q == CONVERT && adc_eoc && !first;
    tmo = state_q == CONVERT && !hit && expire;
    settle_done = state_q == SETTLE && expire;
    adv = state_q == IDLE || tmo || (state_q == HOLD && sample_ready);
    state_d = adv ? (go ? SETTLE : IDLE) : hit ? HOLD : settle_done ? CONVERT : state_q;
    chan_d = adv && go ? next_chan(chan_q, chan_mask) : chan_q;
    load = (adv && go) || settle_done;
    load_val = settle_done ? CNT_W'(CONV_CYCLES) : CNT_W'(SETTLE_CYCLES - 1);
    count = state_q == SETTLE || state_q == CONVERT;
    valid_d = hit ? 1'b1 : (state_q == HOLD && sample_ready) ? 1'b0 : valid_q;
    data_d = hit ? adc_data : data_q;
    schan_d = hit ? chan_q : schan_q;
    err_d = tmo || (err_q && !err_clr);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      chan_q <= 3'd7;
      schan_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q <= chan_d;
      schan_q <= schan_d;
      data_q <= data_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign ADCctrl = state_q == IDLE ? 8'h00 : 8'h01 << chan_q;
  assign start = first;
  assign sample_valid = valid_q;
  assign sample_data = data_q;
  assign sample_chan = schan_q;
  assign timeout_err = err_q;
endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer: randomized scan traffic checked against a transaction-level scoreboard
module tb_adc_scan_sequencer;
  localparam int S = 2, C = 12, B = 10;
  logic clk = 0, reset = 1, enable = 0, adc_eoc = 0, sample_ready = 0, err_clr = 0;
  logic [7:0] chan_mask = 0;
  logic [B-1:0] adc_data = 0;
  logic [7:0] ADCctrl;
  logic start, sample_valid, timeout_err;
  logic [B-1:0] sample_data;
  logic [2:0] sample_chan;
  adc_scan_sequencer #(.ADC_BITS(B), .SETTLE_CYCLES(S), .CONV_CYCLES(C)) dut (
    .clk(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask), .adc_eoc(adc_eoc),
    .adc_data(adc_data), .sample_ready(sample_ready), .err_clr(err_clr), .ADCctrl(ADCctrl),
    .start(start), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_chan(sample_chan), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  int ph = 3, settle_n = 0, conv_n = 0, j = 0, exp_chan = 7;
  int ready_pct = 100, clr_pct = 0, force_j = 0;
  bit exp_err = 0, fix_data = 0;
  logic [B-1:0] fix_val = 0, cap = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int nxt(input int c, input logic [7:0] m);
    for (int d = 1; d <= 8; d++) if (m[(c + d) % 8]) return (c + d) % 8;
    return c;
  endfunction
  function automatic logic [7:0] oh(input int c);
    logic [7:0] r;
    r = 8'h01 << c;
    return r;
  endfunction
  task automatic adv();
    if (enable && chan_mask != 0) begin
      exp_chan = nxt(exp_chan, chan_mask);
      ph = 0;
      settle_n = 1;
      chk("adv_ctrl", ADCctrl, oh(exp_chan));
    end else begin
      ph = 3;
      chk("idle_ctrl", ADCctrl, 0);
    end
  endtask
  task automatic step();
    bit tmo;
    tmo = 0;
    @(negedge clk);
    if (reset) begin
      chk("rst_ctrl", ADCctrl, 0);
      chk("rst_start", start, 0);
      chk("rst_valid", sample_valid, 0);
      chk("rst_data", sample_data, 0);
      chk("rst_chan", sample_chan, 0);
      ph = 3;
      exp_chan = 7;
      settle_n = 0;
    end else case (ph)
      3: begin
        chk("idle_valid", sample_valid, 0);
        chk("idle_start", start, 0);
        if (enable && chan_mask != 0) begin
          exp_chan = nxt(exp_chan, chan_mask);
          ph = 0;
          settle_n = 1;
          chk("wake_ctrl", ADCctrl, oh(exp_chan));
        end else chk("idle_ctrl", ADCctrl, 0);
      end
      0: begin
        chk("settle_valid", sample_valid, 0);
        chk("settle_ctrl", ADCctrl, oh(exp_chan));
        if (start) begin
          chk("settle_len", settle_n, S);
          ph = 1;
          conv_n = 1;
          j = force_j != 0 ? force_j : $urandom_range(1, C + 3);
        end else settle_n++;
      end
      1: begin
        conv_n++;
        if (j >= 2 && j <= C + 1 && conv_n == j + 1) begin
          chk("cap_valid", sample_valid, 1);
          chk("cap_chan", sample_chan, exp_chan);
          chk("cap_data", sample_data, cap);
          chk("cap_ctrl", ADCctrl, oh(exp_chan));
          ph = 2;
        end else if (conv_n == C + 2) begin
          chk("tmo_valid", sample_valid, 0);
          tmo = 1;
          adv();
        end else begin
          chk("conv_valid", sample_valid, 0);
          chk("conv_start", start, 0);
          chk("conv_ctrl", ADCctrl, oh(exp_chan));
        end
      end
      default: begin
        if (sample_ready) begin
          chk("xfer_drop", sample_valid, 0);
          adv();
        end else begin
          chk("hold_valid", sample_valid, 1);
          chk("hold_chan", sample_chan, exp_chan);
          chk("hold_data", sample_data, cap);
          chk("hold_ctrl", ADCctrl, oh(exp_chan));
          chk("hold_start", start, 0);
        end
      end
    endcase
    exp_err = reset ? 0 : tmo ? 1 : err_clr ? 0 : exp_err;
    chk("timeout_err", timeout_err, exp_err);
    adc_eoc = !reset && ph == 1 && conv_n == j;
    adc_data = fix_data ? fix_val : B'($urandom);
    if (adc_eoc) cap = adc_data;
    sample_ready = $urandom_range(0, 99) < ready_pct;
    err_clr = $urandom_range(0, 99) < clr_pct;
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic run_until(input int target, input int max);
    for (int k = 0; k < max && ph != target; k++) step();
    if (ph != target) chk("wait_phase", ph, target);
  endtask
  initial begin
    run(2);
    reset = 0;
    chan_mask = 8'h05;
    enable = 1;
    force_j = 6;
    fix_data = 1;
    fix_val = 10'h155;
    run(80);
    chan_mask = 8'h80;
    run(40);
    ready_pct = 0;
    run_until(2, 100);
    run(20);
    ready_pct = 100;
    run(5);
    chan_mask = 8'h02;
    force_j = 99;
    run(60);
    clr_pct = 100;
    run(3);
    clr_pct = 0;
    force_j = 1;
    run(40);
    clr_pct = 100;
    run(3);
    clr_pct = 0;
    force_j = 5;
    run_until(1, 100);
    enable = 0;
    run_until(3, 100);
    run(5);
    enable = 1;
    chan_mask = 8'hFF;
    force_j = 0;
    run_until(1, 100);
    reset = 1;
    run(1);
    reset = 0;
    run(40);
    fix_data = 0;
    clr_pct = 5;
    for (int p = 0; p < 20; p++) begin
      chan_mask = $urandom_range(0, 9) == 0 ? 8'h00 : 8'($urandom_range(1, 255));
      enable = $urandom_range(0, 9) != 0;
      ready_pct = $urandom_range(10, 100);
      run(200);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

Interface
REQ-001 Parameter ADC_BITS, default 10, SAR result width.
REQ-002 Parameter SETTLE_CYCLES, default 2, mux settle cycles before start (range 1..15).
REQ-003 Parameter CONV_CYCLES, default 12, max cycles from start to adc_eoc before timeout (range 2..63).
REQ-004 clk  input  1  sole clock, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  scanning enabled.
REQ-007 chan_mask  input  8  channel enable bits, bit i = channel i.
REQ-008 adc_eoc  input  1  SAR end-of-conversion strobe.
REQ-009 adc_data  input  ADC_BITS  SAR result, valid when adc_eoc=1.
REQ-010 sample_ready  input  1  downstream accepts sample.
REQ-011 err_clr  input  1  clears timeout_err.
REQ-012 ADCctrl  output  8  one-hot analog mux select.
REQ-013 start  output  1  one-cycle SAR start pulse.
REQ-014 sample_valid  output  1  sample_data/sample_chan valid.
REQ-015 sample_data  output  ADC_BITS  captured conversion result.
REQ-016 sample_chan  output  3  channel index of sample_data.
REQ-017 timeout_err  output  1  sticky: conversion timed out.

Function
REQ-018 FSM states SHALL be IDLE, SETTLE, CONVERT, HOLD.
REQ-019 Channel pointer chan (3 bits) SHALL select next channel as lowest-index set bit of chan_mask strictly after chan, wrapping 7->0; chan itself is chosen only if it is the sole set bit.
REQ-020 IDLE -> SETTLE when enable=1 and chan_mask!=0, loading next channel; otherwise remain IDLE.
REQ-021 ADCctrl SHALL equal one-hot(chan) in SETTLE, CONVERT, HOLD and 8'h00 in IDLE.
REQ-022 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CONVERT.
REQ-023 start SHALL be 1 only on the first CONVERT cycle.
REQ-024 adc_eoc SHALL be ignored on the start cycle and in all states except CONVERT.
REQ-025 adc_eoc=1 in CONVERT cycles 2..CONV_CYCLES+1 (counting the start cycle as 1): capture adc_data into sample_data, chan into sample_chan, go HOLD; sample_valid=1 from the next cycle.
REQ-026 No adc_eoc by end of CONVERT cycle CONV_CYCLES+1: set timeout_err, no sample, advance as in REQ-028.
REQ-027 HOLD: sample_valid, sample_data, sample_chan held stable until sample_ready=1; transfer occurs in the cycle sample_valid & sample_ready.
REQ-028 On transfer (or timeout): if enable=1 and chan_mask!=0, go SETTLE with next channel per REQ-019 using current chan_mask; else go IDLE.
REQ-029 enable or chan_mask changes during SETTLE/CONVERT/HOLD SHALL NOT abort the current channel; they take effect at REQ-028.
REQ-030 sample_valid SHALL drop the cycle after transfer.
REQ-031 err_clr clears timeout_err; simultaneous timeout and err_clr -> timeout_err=1.

Reset
REQ-032 reset=1 SHALL force IDLE, chan=7, ADCctrl=0, start=0, sample_valid=0, sample_data=0, sample_chan=0, timeout_err=0, counters=0, in the following cycle, regardless of state (including mid-conversion and mid-HOLD).
REQ-033 reset has priority over all other inputs.

Structure
REQ-034 State encoding and default parameter values SHALL live in shared package adc_pkg.
REQ-035 The settle/convert cycle count SHALL be a single sub-module adc_cycle_timer (load, count, expire) instantiated once.

Verification
REQ-036 Mask 8'h05, enable=1, eoc 5 cycles after start, data 10'h155, ready=1 -> samples chan 0,2,0,2 with ADCctrl 01,04,01,04, start 2 cycles after each ADCctrl change.
REQ-037 Mask 8'h80, ready held 0 for 20 cycles -> sample_valid and sample_chan=7 stable 20 cycles, no further start, ADCctrl=8'h80.
REQ-038 Mask 8'h02, no adc_eoc -> timeout_err=1 after 13 cycles in CONVERT, no sample_valid, new start after 2 settle cycles; err_clr -> 0.
REQ-039 adc_eoc asserted on start cycle only -> ignored, timeout occurs.
REQ-040 reset asserted in CONVERT with mask 8'hFF -> all outputs zero next cycle; after release first channel is 0.
REQ-041 enable dropped in CONVERT -> sample completes and transfers, then IDLE with ADCctrl=0.
